// File: rtl/arf_mul_sched.sv
// ARF evaluation scheduled onto one shared multiplier through a req/gnt port.
// Latency: 2*MUL_LAT+11 cycles from input accept to out_valid with mul_gnt tied high; each stall adds one.
// Backpressure: in_ready only in IDLE; mul_req/mul_a/mul_b hold until granted; DONE holds results until out_ready.
module arf_mul_sched #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3,
  parameter logic signed [WIDTH-1:0] C1 = WIDTH'(1),
  parameter logic signed [WIDTH-1:0] C2 = WIDTH'(2),
  parameter logic signed [WIDTH-1:0] C3 = WIDTH'(3),
  parameter logic signed [WIDTH-1:0] C4 = WIDTH'(4),
  parameter logic signed [WIDTH-1:0] C5 = WIDTH'(5),
  parameter logic signed [WIDTH-1:0] C6 = WIDTH'(6),
  parameter logic signed [WIDTH-1:0] C7 = WIDTH'(7),
  parameter logic signed [WIDTH-1:0] C8 = WIDTH'(8)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_1_0,
  input  logic signed [WIDTH-1:0] in_2_0,
  input  logic signed [WIDTH-1:0] in_3_0,
  input  logic signed [WIDTH-1:0] in_4_0,
  input  logic signed [WIDTH-1:0] in_5_0,
  input  logic signed [WIDTH-1:0] in_6_0,
  input  logic signed [WIDTH-1:0] in_7_0,
  input  logic signed [WIDTH-1:0] in_8_0,
  input  logic signed [WIDTH-1:0] in_13_1,
  input  logic signed [WIDTH-1:0] in_14_1,
  output logic                    mul_req,
  input  logic                    mul_gnt,
  output logic signed [WIDTH-1:0] mul_a,
  output logic signed [WIDTH-1:0] mul_b,
  input  logic signed [WIDTH-1:0] mul_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_27,
  output logic signed [WIDTH-1:0] out_28
);

  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   smp_q [8];
  logic [WIDTH-1:0]   in13_q, in14_q;
  logic [WIDTH-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic [3:0]         op_q, op_nxt;
  logic               in_ready_q, mul_req_q, out_valid_q;
  logic [WIDTH-1:0]   mul_a_q, mul_b_q, out_27_q, out_28_q;
  logic [MUL_LAT-1:0] vld_pipe_q;
  logic [MUL_LAT-1:0][3:0] tag_pipe_q;
  logic               issue, ret_vld;
  logic [3:0]         ret_tag;

  assign in_ready  = in_ready_q;
  assign mul_req   = mul_req_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_27    = out_27_q;
  assign out_28    = out_28_q;

  assign issue   = mul_req_q && mul_gnt;
  assign ret_vld = vld_pipe_q[MUL_LAT-1];
  assign ret_tag = tag_pipe_q[MUL_LAT-1];
  assign op_nxt  = op_q + 4'd1;

  function automatic logic [WIDTH-1:0] coef(input logic [3:0] k);
    case (k)
      4'd0:    coef = C1;
      4'd1:    coef = C2;
      4'd2:    coef = C3;
      4'd3:    coef = C4;
      4'd4:    coef = C5;
      4'd5:    coef = C6;
      4'd6:    coef = C7;
      4'd7:    coef = C8;
      default: coef = '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] sample(input logic [3:0] k);
    case (k)
      4'd0:    sample = smp_q[0];
      4'd1:    sample = smp_q[1];
      4'd2:    sample = smp_q[2];
      4'd3:    sample = smp_q[3];
      4'd4:    sample = smp_q[4];
      4'd5:    sample = smp_q[5];
      4'd6:    sample = smp_q[6];
      4'd7:    sample = smp_q[7];
      default: sample = '0;
    endcase
  endfunction

  // Returning products of ops 0-3 accumulate into s1, ops 4-7 into s2.
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (ret_vld) begin
      if (ret_tag < 4'd4)      s1_d = s1_q + mul_p;
      else if (ret_tag < 4'd8) s2_d = s2_q + mul_p;
    end
  end

  // Tag pipe: follows each granted issue so its product is routed by op index MUL_LAT cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= issue;
      tag_pipe_q[0] <= op_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  // Sequencer: capture, issue ops 0-7, drain, issue ops 8-9, drain, present result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      mul_req_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_27_q    <= '0;
      out_28_q    <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      op_q        <= '0;
      in13_q      <= '0;
      in14_q      <= '0;
      for (int i = 0; i < 8; i++) smp_q[i] <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      // op8/op9 products complete the two outputs; s1/s2 are final by then.
      if (ret_vld && ret_tag == 4'd8) out_27_q <= mul_p + s2_q;
      if (ret_vld && ret_tag == 4'd9) out_28_q <= mul_p - s1_q;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            smp_q[0] <= in_1_0;
            smp_q[1] <= in_2_0;
            smp_q[2] <= in_3_0;
            smp_q[3] <= in_4_0;
            smp_q[4] <= in_5_0;
            smp_q[5] <= in_6_0;
            smp_q[6] <= in_7_0;
            smp_q[7] <= in_8_0;
            in13_q     <= in_13_1;
            in14_q     <= in_14_1;
            s1_q       <= '0;
            s2_q       <= '0;
            op_q       <= 4'd0;
            mul_req_q  <= 1'b1;
            mul_a_q    <= in_1_0;
            mul_b_q    <= C1;
            in_ready_q <= 1'b0;
            state_q    <= ISSUE1;
          end
        end
        ISSUE1: begin
          if (mul_gnt) begin
            if (op_q == 4'd7) begin
              mul_req_q <= 1'b0;
              mul_a_q   <= '0;
              mul_b_q   <= '0;
              state_q   <= WAIT1;
            end else begin
              op_q    <= op_nxt;
              mul_a_q <= sample(op_nxt);
              mul_b_q <= coef(op_nxt);
            end
          end
        end
        WAIT1: begin
          // op7 is the last first-stage product, so s1 is already complete here.
          if (ret_vld && ret_tag == 4'd7) begin
            op_q      <= 4'd8;
            mul_req_q <= 1'b1;
            mul_a_q   <= s1_q;
            mul_b_q   <= in13_q;
            state_q   <= ISSUE2;
          end
        end
        ISSUE2: begin
          if (mul_gnt) begin
            if (op_q == 4'd8) begin
              op_q    <= 4'd9;
              mul_a_q <= s2_q;
              mul_b_q <= in14_q;
            end else begin
              mul_req_q <= 1'b0;
              mul_a_q   <= '0;
              mul_b_q   <= '0;
              state_q   <= WAIT2;
            end
          end
        end
        WAIT2: begin
          if (ret_vld && ret_tag == 4'd9) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/arf_mul_sched.md
Name: arf_mul_sched

Overview:
- Sequences one ARF evaluation onto a single multiplier that is shared with other blocks, instead of using dedicated multipliers.
- Takes the 10 ARF inputs through a valid/ready handshake and issues 10 multiplies through a req/gnt port.
- Accumulates the in-order products and returns out_27/out_28 through a valid/ready handshake.
- Serves as the resource-constrained (scheduled) counterpart of the fully parallel ARF datapaths.

Parameters:
- WIDTH, 32, data width of all inputs, outputs and multiplier operands (signed)
- MUL_LAT, 3, fixed multiplier latency in cycles from granted issue to product on mul_p (>=1)
- C1..C8, 1..8 (Ck = k), signed WIDTH-bit coefficients for in_k_0

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept an input vector
- in_1_0..in_8_0  in  WIDTH each  signed sample inputs
- in_13_1, in_14_1  in  WIDTH each  signed second-stage inputs
- mul_req  out  1  multiply request
- mul_gnt  in  1  request granted this cycle
- mul_a, mul_b  out  WIDTH each  signed operands, valid while mul_req=1
- mul_p  in  WIDTH  low WIDTH bits of product, valid exactly MUL_LAT cycles after a granted issue
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_27, out_28  out  WIDTH each  signed results

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset values: in_ready=1, mul_req=0, mul_a=mul_b=0, out_valid=0, out_27=out_28=0, state IDLE.
- Reset also clears s1, s2, the op counters and the in-flight tag pipe.
- Arithmetic: all arithmetic is two's-complement modulo 2^WIDTH (wrap, no saturation). Products are the low WIDTH bits.
- Function:
  - s1 = sum of Ck*in_k_0 for k=1..4
  - s2 = sum of Ck*in_k_0 for k=5..8
  - out_27 = s1*in_13_1 + s2
  - out_28 = s2*in_14_1 - s1
- Input handshake: in_ready=1 only in IDLE. A vector is captured on in_valid && in_ready, and the next state is ISSUE1.
- Ops: op0..7 are (in_k_0, Ck) for k=op+1. op8 is (s1, in_13_1). op9 is (s2, in_14_1).
- Issue rule:
  - mul_req=1 in ISSUE1/ISSUE2 while ops remain. mul_a/mul_b show the current op.
  - An issue occurs on mul_req && mul_gnt; the op index then advances next cycle.
  - Without gnt, mul_req, mul_a and mul_b hold stable.
  - At most one issue per cycle.
- Return tracking:
  - A MUL_LAT-deep valid/tag pipe is shifted every cycle. mul_p is sampled when the pipe output is valid.
  - Results return in issue order.
  - Ops 0-3 add to s1; ops 4-7 add to s2. s1 and s2 are cleared on input accept.
  - op8 result + s2 goes to out_27; op9 result - s1 goes to out_28.
- States:
  - IDLE -> ISSUE1 on accept.
  - ISSUE1 -> WAIT1 after op7 is granted (mul_req drops).
  - WAIT1 -> ISSUE2 when all 8 results are captured.
  - ISSUE2 -> WAIT2 after op9 is granted.
  - WAIT2 -> DONE when the op9 result is captured.
  - DONE: out_valid=1; outputs held stable; DONE -> IDLE on out_ready.
- Latency: with mul_gnt tied to 1, out_valid rises 2*MUL_LAT+11 cycles after the accept cycle. Each gnt stall cycle adds one.
- Back-to-back: in_ready returns the cycle after the out handshake. There is no overlap of evaluations.
- Reset mid-operation: the evaluation is abandoned, in-flight products are discarded (tag pipe cleared), and mul_p arriving after reset is ignored.
- mul_gnt while mul_req=0 is ignored.

Test Plan:
- Defaults (MUL_LAT=3), mul_gnt=1, all inputs 1 -> s1=10, s2=26. out_27=36, out_28=16. out_valid asserted exactly 17 cycles after accept.
- in_k_0=-1 for all k, in_13_1=2, in_14_1=-3 -> s1=-10, s2=-26. out_27=-46, out_28=88.
- mul_gnt random (~50%) with the vector from the previous test -> identical results. mul_a/mul_b stable while mul_req && !mul_gnt. Exactly 10 grants per evaluation.
- in_1_0=32'h7FFFFFFF, other in_k_0=0, in_13_1=2, in_14_1=0 -> s1=32'h7FFFFFFF, s2=0. out_27=32'hFFFFFFFE (wrap), out_28=32'h80000001.
- Hold out_ready=0 for 20 cycles in DONE -> outputs stable, in_ready=0. After release, a second vector is accepted the cycle after the handshake and gives the correct result.
- Assert rst during WAIT1 with products in flight, then send the all-ones vector -> reset values hold, stale mul_p is ignored, and the result is 36/16.
